// File: rtl/regfile_onehot_8x32.sv
// regfile_onehot_8x32: 8-entry register bank with a one-hot write port and two
// combinational read ports. Multi-bit write-enable vectors are rejected,
// flagged for one cycle on wr_err and counted in a saturating err_cnt.
// Optional feature macro: READ_BYPASS_EN (same-cycle write-through on reads).
module regfile_onehot_8x32 #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ZERO_REG  = 1,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           we_onehot,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [2:0]           raddr_a,
   input  logic [2:0]           raddr_b,
   output logic [WIDTH-1:0]     rdata_a,
   output logic [WIDTH-1:0]     rdata_b,
   output logic                 wr_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned NREG = 8;
   localparam int unsigned AW   = 3;
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   logic [WIDTH-1:0] regs [NREG];
   logic             any_we;
   logic             multi_we;
   logic             legal_we;
   logic [NREG-1:0]  wen;

   // Classify the enable vector: x & (x-1) is non-zero iff more than one bit is set
   always_comb begin
      any_we   = |we_onehot;
      multi_we = |(we_onehot & (we_onehot - 8'd1));
      legal_we = any_we & ~multi_we;
   end

   // Per-register commit strobes; a hardwired zero register never accepts a write
   always_comb begin
      wen = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         wen[i] = legal_we & we_onehot[i];
      end
      if (ZERO_REG != 0) begin
         wen[0] = 1'b0;
      end
   end

   // Register storage, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (wen[i]) begin
               regs[i] <= wdata;
            end
         end
      end
   end

   // One-cycle illegal-write flag and saturating illegal-write counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_err  <= 1'b0;
         err_cnt <= '0;
      end else begin
         wr_err <= multi_we;
         if (multi_we && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
         end
      end
   end

   // Read port A: stored value, optional write-through, zero register forced last
   always_comb begin
      rdata_a = regs[raddr_a];
`ifdef READ_BYPASS_EN
      if (wen[raddr_a]) begin
         rdata_a = wdata;
      end
`endif
      if ((ZERO_REG != 0) && (raddr_a == AW'(0))) begin
         rdata_a = '0;
      end
   end

   // Read port B: identical structure to port A
   always_comb begin
      rdata_b = regs[raddr_b];
`ifdef READ_BYPASS_EN
      if (wen[raddr_b]) begin
         rdata_b = wdata;
      end
`endif
      if ((ZERO_REG != 0) && (raddr_b == AW'(0))) begin
         rdata_b = '0;
      end
   end

endmodule

// File: tb/tb_regfile_onehot_8x32.sv
// Bench for regfile_onehot_8x32: one instance with a hardwired zero register and
// one with an ordinary register 0, driven in parallel from a directed sequence.
module tb_regfile_onehot_8x32;

   logic        clk;
   logic        reset;
   logic [7:0]  we_onehot;
   logic [31:0] wdata;
   logic [2:0]  raddr_a;
   logic [2:0]  raddr_b;
   logic [31:0] rdata_a,    rdata_b;
   logic [31:0] nz_rdata_a, nz_rdata_b;
   logic        wr_err,     nz_wr_err;
   logic [7:0]  err_cnt,    nz_err_cnt;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;
   sb_item_t sb[$];

   // Reference model state
   logic [31:0] m1 [8];
   logic [31:0] m0 [8];
   int          m_cnt;
   logic        m_err;

   regfile_onehot_8x32 #(.WIDTH(32), .ZERO_REG(1), .ERR_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .we_onehot(we_onehot), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .wr_err(wr_err), .err_cnt(err_cnt));

   regfile_onehot_8x32 #(.WIDTH(32), .ZERO_REG(0), .ERR_CNT_W(8)) dut_nz (
      .clk(clk), .reset(reset), .we_onehot(we_onehot), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nz_rdata_a), .rdata_b(nz_rdata_b),
      .wr_err(nz_wr_err), .err_cnt(nz_err_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m1[i] = '0;
         m0[i] = '0;
      end
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   function automatic logic [31:0] exp_rd(input bit zr, input logic [2:0] a);
      logic [31:0] v;
      if (zr && a == 3'd0) return 32'h0;
      v = zr ? m1[a] : m0[a];
`ifdef READ_BYPASS_EN
      if ($countones(we_onehot) == 1 && we_onehot[a]) v = wdata;
`endif
      return v;
   endfunction

   task automatic push(input string t, input logic [31:0] e);
      sb_item_t it;
      it.tag = t;
      it.exp = e;
      sb.push_back(it);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      sb_item_t it;
      tests++;
      if (sb.size() == 0) begin
         failed++;
         $error("FAIL sb_empty: observed %h with no expected value queued", obs);
         return;
      end
      it = sb.pop_front();
      assert (obs === it.exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
   endtask

   // Apply inputs now, take one rising edge, update the model, then idle the write port
   task automatic drive_edge(input logic [7:0] we, input logic [31:0] wd);
      int idx;
      we_onehot = we;
      wdata     = wd;
      @(posedge clk);
      #1;
      if ($countones(we) == 1) begin
         idx = 0;
         for (int i = 0; i < 8; i++) if (we[i]) idx = i;
         m0[idx] = wd;
         if (idx != 0) m1[idx] = wd;
      end
      if ($countones(we) > 1) begin
         m_err = 1'b1;
         if (m_cnt < 255) m_cnt++;
      end else begin
         m_err = 1'b0;
      end
      we_onehot = 8'h00;
   endtask

   task automatic step(input logic [7:0] we, input logic [31:0] wd);
      @(negedge clk);
      drive_edge(we, wd);
   endtask

   task automatic check_reads(input logic [2:0] a, input logic [2:0] b);
      raddr_a = a;
      raddr_b = b;
      #1;
      push($sformatf("rd_a[%0d]", a), exp_rd(1'b1, a));
      push($sformatf("rd_b[%0d]", b), exp_rd(1'b1, b));
      push($sformatf("nz_rd_a[%0d]", a), exp_rd(1'b0, a));
      push($sformatf("nz_rd_b[%0d]", b), exp_rd(1'b0, b));
      pop_cmp(rdata_a);
      pop_cmp(rdata_b);
      pop_cmp(nz_rdata_a);
      pop_cmp(nz_rdata_b);
   endtask

   task automatic check_status();
      push("wr_err", {31'b0, m_err});
      push("err_cnt", 32'(m_cnt));
      push("nz_wr_err", {31'b0, m_err});
      push("nz_err_cnt", 32'(m_cnt));
      pop_cmp({31'b0, wr_err});
      pop_cmp({24'b0, err_cnt});
      pop_cmp({31'b0, nz_wr_err});
      pop_cmp({24'b0, nz_err_cnt});
   endtask

   initial begin
      reset     = 1'b1;
      we_onehot = 8'h00;
      wdata     = 32'h0;
      raddr_a   = 3'd0;
      raddr_b   = 3'd0;
      model_reset();

      // Reset state on every address and both ports
      repeat (2) @(posedge clk);
      #1;
      check_status();
      for (int a = 0; a < 8; a++) check_reads(3'(a), 3'(7 - a));
      @(negedge clk);
      reset = 1'b0;

      // Single legal write to reg3
      step(8'b0000_1000, 32'hDEADBEEF);
      check_status();
      check_reads(3'd3, 3'd3);
      for (int a = 0; a < 8; a++) check_reads(3'(a), 3'(a));

      // Write to reg0: discarded with a zero register, stored otherwise
      step(8'b0000_0001, 32'h12345678);
      check_status();
      check_reads(3'd0, 3'd0);

      // Illegal two-bit write leaves storage alone and pulses wr_err once
      step(8'b0010_0000, 32'hAAAA0000);
      step(8'b0010_0100, 32'hFFFFFFFF);
      check_status();
      check_reads(3'd2, 3'd5);
      step(8'b0000_0000, 32'h0);
      check_status();

      // Sustained illegal writes saturate the counter
      for (int i = 0; i < 300; i++) begin
         step(8'b1100_0000, 32'h0F0F0F0F);
         check_status();
      end
      step(8'b1111_1111, 32'h0);
      check_status();
      check_reads(3'd6, 3'd7);
      step(8'b0000_0000, 32'h0);
      check_status();

      // Same-cycle read/write collision on reg4
      step(8'b0001_0000, 32'h11111111);
      @(negedge clk);
      we_onehot = 8'b0001_0000;
      wdata     = 32'h22222222;
      check_reads(3'd4, 3'd3);
      drive_edge(8'b0001_0000, 32'h22222222);
      check_reads(3'd4, 3'd4);

      // Collision on reg0
      @(negedge clk);
      we_onehot = 8'b0000_0001;
      wdata     = 32'h55555555;
      check_reads(3'd0, 3'd0);
      drive_edge(8'b0000_0001, 32'h55555555);
      check_reads(3'd0, 3'd0);

      // Illegal cycle never bypasses
      @(negedge clk);
      we_onehot = 8'b0011_0000;
      wdata     = 32'h33333333;
      check_reads(3'd4, 3'd5);
      drive_edge(8'b0011_0000, 32'h33333333);
      check_status();
      check_reads(3'd4, 3'd5);

      // Asynchronous reset between edges
      step(8'b1000_0000, 32'hCAFEF00D);
      check_reads(3'd7, 3'd7);
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_status();
      check_reads(3'd7, 3'd4);
      @(posedge clk);
      #1;
      check_reads(3'd7, 3'd3);

      // Write presented in the deassertion cycle lands on the next edge
      @(negedge clk);
      reset = 1'b0;
      drive_edge(8'b1000_0000, 32'h0BADC0DE);
      check_status();
      check_reads(3'd7, 3'd7);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/regfile_onehot_8x32.md
Name: regfile_onehot_8x32

Overview:
- 8-entry register bank written through a one-hot write-enable vector taken directly from the 3-to-8 write-select decoder output. Sits directly downstream of that decoder in the datapath.
- Provides two asynchronous read ports for the ALU operand path.
- Checks that the write-enable vector really is one-hot. An illegal vector is rejected, flagged, and counted.

Parameters:
- WIDTH, 32, data width of each register and of the write/read data ports.
- ZERO_REG, 1, 1 = register 0 hardwired to zero (MIPS $zero semantics); 0 = register 0 is an ordinary register.
- ERR_CNT_W, 8, width of the saturating illegal-write counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous reset, active-high.
- we_onehot  input  8  write enables, one bit per register; bit i selects register i; all-zero = no write.
- wdata  input  WIDTH  write data.
- raddr_a  input  3  read address, port A.
- raddr_b  input  3  read address, port B.
- rdata_a  output  WIDTH  read data, port A (combinational).
- rdata_b  output  WIDTH  read data, port B (combinational).
- wr_err  output  1  registered one-cycle pulse: previous cycle's we_onehot had more than one bit set.
- err_cnt  output  ERR_CNT_W  saturating count of illegal write cycles since reset.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - While reset=1: all 8 registers = 0, wr_err = 0, err_cnt = 0.
  - Reset asserting mid-operation clears state immediately, without waiting for a clock edge.
  - A write presented in the same cycle that reset deasserts is captured at the first rising edge after deassertion.
- Write:
  - On a rising edge, if we_onehot has exactly one bit i set: reg[i] <= wdata.
  - we_onehot = 0: no register changes, no error.
  - More than one bit set: no register changes; wr_err = 1 for exactly the following cycle; err_cnt increments by 1.
  - err_cnt saturates at 2^ERR_CNT_W-1 and does not wrap.
- Zero register: with ZERO_REG=1, a one-hot write to bit 0 is legal but discarded. reg[0] stays 0 and wr_err is not raised.
- Read:
  - rdata_x = reg[raddr_x] combinationally, zero-latency.
  - With ZERO_REG=1, address 0 always reads 0.
  - Both ports may address the same register simultaneously, with identical results.
- Same-cycle read/write collision (read address equals the register being written): default is read-old-value. The written value is visible from the cycle after the edge. See the optional feature for the alternative.
- Latency:
  - Write to visible read: 1 edge.
  - Illegal write to wr_err: 1 edge.
  - Illegal write to err_cnt update: 1 edge.
- Consecutive illegal cycles:
  - wr_err stays high for every cycle that follows an illegal cycle.
  - err_cnt increments once per illegal cycle.
- X on we_onehot is treated as don't-care by RTL. Verification must drive known values.

Optional Feature:
- Macro READ_BYPASS_EN.
- Defined: if a legal single-bit write to register i is present this cycle and raddr_x == i, rdata_x returns wdata combinationally (write-through bypass).
  - With ZERO_REG=1 and i=0, bypass still returns 0.
  - No bypass is applied on illegal multi-bit cycles.
- Undefined: no bypass logic; collisions return the stored (old) value as stated in Behaviour.

Test Plan:
- Reset, then read all 8 addresses on both ports -> every rdata = 0x00000000, wr_err = 0, err_cnt = 0.
- we_onehot=8'b0000_1000, wdata=0xDEADBEEF, one edge; then raddr_a=3, raddr_b=3 -> both read 0xDEADBEEF; all other registers still 0.
- we_onehot=8'b0000_0001, wdata=0x12345678 with ZERO_REG=1 -> reg0 reads 0, wr_err stays 0. Repeat with ZERO_REG=0 -> reg0 reads 0x12345678.
- Preload reg5=0xAAAA0000, then we_onehot=8'b0010_0100, wdata=0xFFFFFFFF -> reg2 and reg5 unchanged, wr_err=1 for exactly one cycle, err_cnt=1. Hold illegal for 300 cycles -> err_cnt=255 and stays at 255.
- Preload reg4=0x11111111, then in one cycle we_onehot=8'b0001_0000, wdata=0x22222222, raddr_a=4 -> before the edge, rdata_a=0x11111111 without READ_BYPASS_EN and 0x22222222 with it; after the edge both builds give 0x22222222.
- Write reg7=0xCAFEF00D, assert reset asynchronously mid-cycle between edges -> rdata for addr 7 goes to 0 immediately and err_cnt=0. Deassert and write reg7 again -> value visible after one edge.
